ws2812_input_decoder: RTL and testbench

Receives a WS2812-style single-wire NRZ pulse stream, classifies each high pulse as a 0 or 1 bit by its width, and assembles bits MSB-first into bytes presented with a one-cycle valid strobe. It also detects the long-low reset gap that ends a frame and flags malformed pulses. It sits on the input side of the LED-chain datapath, for loopback checking of our transmit path and for daisy-chained controller boards.

---
 rtl/ws2812_input_decoder_if.sv | 24 ++
 rtl/ws2812_input_decoder.sv | 159 +++++++++++++++
 tb/tb_ws2812_input_decoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_input_decoder_if.sv
// Serial line and decoded-byte strobes for the WS2812 input decoder.
interface ws2812_input_decoder_if;
  logic       in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_end;
  logic       error;

  modport master (
    input  in,
    output data_out,
    output data_valid,
    output frame_end,
    output error
  );

  modport slave (
    output in,
    input  data_out,
    input  data_valid,
    input  frame_end,
    input  error
  );
endinterface

// File: rtl/ws2812_input_decoder.sv
// WS2812 NRZ input decoder: classifies high pulses by width into bits,
// assembles bytes MSB-first, flags frame-end gaps and malformed pulses.
module ws2812_input_decoder #(
  parameter int INPUT_CLOCK       = 12_000_000,
  parameter int THRESH_BIT        = $rtoi(575e-9 * INPUT_CLOCK),
  parameter int MAX_HIGH          = $rtoi(2000e-9 * INPUT_CLOCK),
  parameter int TIME_RESET_DETECT = $rtoi(40e-6 * INPUT_CLOCK)
) (
  input logic                    clk,
  input logic                    rst,
  ws2812_input_decoder_if.master bus
);

  localparam int HW = $clog2(MAX_HIGH + 1) + 1;
  localparam int LW = $clog2(TIME_RESET_DETECT) + 1;

  localparam logic [HW-1:0] H_THRESH = HW'(THRESH_BIT);
  localparam logic [HW-1:0] H_MAX    = HW'(MAX_HIGH);
  localparam logic [LW-1:0] L_GAP    = LW'(TIME_RESET_DETECT);

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

  state_t          state, state_d;
  logic            sync1, sync2;
  logic [HW-1:0]   hcnt, hcnt_d;
  logic [LW-1:0]   lcnt, lcnt_d;
  logic [2:0]      bitcnt, bitcnt_d;
  logic [6:0]      shift, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            fend_q, fend_d;
  logic            err_q, err_d;
  logic            bit_val;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.in;
      sync2 <= sync1;
    end
  end

  // State, counter, datapath and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_GAP;
      hcnt    <= '0;
      lcnt    <= '0;
      bitcnt  <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      hcnt    <= hcnt_d;
      lcnt    <= lcnt_d;
      bitcnt  <= bitcnt_d;
      shift   <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fend_q  <= fend_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter updates, bit decode and strobe generation.
  always_comb begin
    state_d  = state;
    hcnt_d   = hcnt;
    lcnt_d   = lcnt;
    bitcnt_d = bitcnt;
    shift_d  = shift;
    data_d   = data_q;
    valid_d  = 1'b0;
    fend_d   = 1'b0;
    err_d    = 1'b0;
    bit_val  = (hcnt > H_THRESH);

    case (state)
      // Refuse to lock on mid-frame: require one full reset gap first.
      WAIT_GAP: begin
        if (sync2) begin
          lcnt_d = '0;
        end else if (lcnt == L_GAP) begin
          state_d = IDLE;
        end else if (lcnt != '1) begin
          lcnt_d = lcnt + 1'b1;
        end
      end

      IDLE: begin
        if (sync2) begin
          hcnt_d  = HW'(1);
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (sync2) begin
          if (hcnt == H_MAX) begin
            err_d    = 1'b1;
            bitcnt_d = '0;
            lcnt_d   = '0;
            state_d  = WAIT_GAP;
          end else if (hcnt != '1) begin
            hcnt_d = hcnt + 1'b1;
          end
        end else begin
          lcnt_d  = LW'(1);
          state_d = LOW;
          if (bitcnt == 3'd7) begin
            data_d   = {shift, bit_val};
            valid_d  = 1'b1;
            bitcnt_d = '0;
          end else begin
            shift_d  = {shift[5:0], bit_val};
            bitcnt_d = bitcnt + 1'b1;
          end
        end
      end

      // Timeout takes priority over a rising edge seen in the same cycle.
      LOW: begin
        if (lcnt == L_GAP) begin
          fend_d  = 1'b1;
          state_d = IDLE;
          if (bitcnt != '0) begin
            err_d    = 1'b1;
            bitcnt_d = '0;
          end
        end else if (sync2) begin
          hcnt_d  = HW'(1);
          state_d = HIGH;
        end else if (lcnt != '1) begin
          lcnt_d = lcnt + 1'b1;
        end
      end

      default: begin
        state_d  = WAIT_GAP;
        hcnt_d   = '0;
        lcnt_d   = '0;
        bitcnt_d = '0;
        shift_d  = '0;
      end
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_end  = fend_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_ws2812_input_decoder.sv
// Directed bench for the WS2812 input decoder at 12 MHz timing
// (THRESH_BIT=6, MAX_HIGH=24, TIME_RESET_DETECT=480).
module tb_ws2812_input_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  ws2812_input_decoder_if bus ();

  ws2812_input_decoder #(
    .INPUT_CLOCK      (12_000_000),
    .THRESH_BIT       (6),
    .MAX_HIGH         (24),
    .TIME_RESET_DETECT(480)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge.
  logic [7:0] rx_q[$];
  int fe_cnt = 0, err_cnt = 0, fe_cyc = -1, err_cyc = -1, valid_cyc = -1;
  int overlap = 0, stretch = 0;
  logic pv = 1'b0, pf = 1'b0, pe = 1'b0;

  always @(negedge clk) begin
    if (bus.data_valid) begin
      rx_q.push_back(bus.data_out);
      valid_cyc = cyc;
    end
    if (bus.frame_end) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (bus.error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.data_valid && bus.error) overlap++;
    if ((bus.data_valid && pv) || (bus.frame_end && pf) || (bus.error && pe)) stretch++;
    pv = bus.data_valid;
    pf = bus.frame_end;
    pe = bus.error;
  end

  int checks = 0;
  int errors = 0;
  int last_fall = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.in = 1'b1;
    repeat (hi) tick();
    bus.in = 1'b0;
    last_fall = cyc;
    repeat (lo) tick();
  endtask

  task automatic send_bits(input logic [7:0] pat, input int nbits,
                           input int hi1, input int hi0, input int lo);
    for (int i = 7; i > 7 - nbits; i--) pulse(pat[i] ? hi1 : hi0, lo);
  endtask

  task automatic hold_low(input int n);
    bus.in = 1'b0;
    repeat (n) tick();
  endtask

  typedef struct {
    logic [7:0] pattern;
    int         hi1;
    int         hi0;
    int         lo;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fe0, err0, got;

    vecs[0] = '{8'hA5, 9, 4, 7, 8'hA5};
    vecs[1] = '{8'h00, 9, 4, 7, 8'h00};
    vecs[2] = '{8'hFF, 9, 4, 7, 8'hFF};
    vecs[3] = '{8'h3C, 9, 4, 7, 8'h3C};
    vecs[4] = '{8'hAA, 7, 6, 7, 8'hAA};  // threshold edges
    vecs[5] = '{8'hFF, 6, 6, 3, 8'h00};  // 6-cycle high is a 0
    vecs[6] = '{8'h81, 24, 1, 1, 8'h81}; // longest legal high, shortest pulses
    vecs[7] = '{8'h00, 7, 7, 2, 8'hFF};  // 7-cycle high is a 1

    // Reset state
    bus.in = 1'b0;
    rst    = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_data_valid", int'(bus.data_valid), 0);
    check("rst_frame_end", int'(bus.frame_end), 0);
    check("rst_error", int'(bus.error), 0);
    tick();
    rst = 1'b0;

    // Pulse train with no prior gap must be ignored
    send_bits(8'hC3, 8, 9, 4, 7);
    send_bits(8'hC3, 8, 9, 4, 7);
    hold_low(500);
    check("midframe_no_valid", rx_q.size(), 0);
    check("midframe_no_fe", fe_cnt, 0);
    check("midframe_no_err", err_cnt, 0);

    // Table stream: one frame of back-to-back bytes
    base = rx_q.size();
    for (int v = 0; v < 8; v++)
      send_bits(vecs[v].pattern, 8, vecs[v].hi1, vecs[v].hi0, vecs[v].lo);
    hold_low(500);
    check("table_count", rx_q.size() - base, 8);
    for (int v = 0; v < 8; v++) begin
      got = (base + v < rx_q.size()) ? int'(rx_q[base + v]) : -1;
      check($sformatf("table_byte%0d", v), got, int'(vecs[v].exp));
    end
    check("table_valid_latency", valid_cyc - last_fall, 3);
    check("table_fe_count", fe_cnt, 1);
    check("table_fe_latency", fe_cyc - last_fall, 483);
    check("table_no_err", err_cnt, 0);

    // Over-long high mid-byte, then lockout until a gap
    base = rx_q.size();
    fe0  = fe_cnt;
    err0 = err_cnt;
    send_bits(8'hFF, 3, 9, 4, 7);
    pulse(25, 7);
    check("longhigh_err", err_cnt - err0, 1);
    send_bits(8'h77, 8, 9, 4, 7);
    check("longhigh_ignored", rx_q.size() - base, 0);
    hold_low(500);
    check("longhigh_no_fe", fe_cnt - fe0, 0);
    send_bits(8'h5A, 8, 9, 4, 7);
    hold_low(500);
    check("recover_count", rx_q.size() - base, 1);
    got = (rx_q.size() > base) ? int'(rx_q[base]) : -1;
    check("recover_byte", got, 'h5A);
    check("recover_fe", fe_cnt - fe0, 1);
    check("recover_err_total", err_cnt - err0, 1);

    // Partial byte at frame end
    base = rx_q.size();
    fe0  = fe_cnt;
    err0 = err_cnt;
    send_bits(8'hF0, 5, 9, 4, 7);
    hold_low(500);
    check("partial_fe", fe_cnt - fe0, 1);
    check("partial_err", err_cnt - err0, 1);
    check("partial_same_cycle", err_cyc, fe_cyc);
    check("partial_no_valid", rx_q.size() - base, 0);
    check("partial_data_held", int'(bus.data_out), 'h5A);

    // Reset asserted as the eighth bit falls: no strobe may escape
    base = rx_q.size();
    fe0  = fe_cnt;
    err0 = err_cnt;
    send_bits(8'hE1, 7, 9, 4, 7);
    bus.in = 1'b1;
    repeat (9) tick();
    bus.in = 1'b0;
    rst    = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_data_out", int'(bus.data_out), 0);
    check("midrst_data_valid", int'(bus.data_valid), 0);
    check("midrst_frame_end", int'(bus.frame_end), 0);
    check("midrst_error", int'(bus.error), 0);
    repeat (5) tick();
    rst = 1'b0;
    hold_low(10);
    check("midrst_no_valid", rx_q.size() - base, 0);
    check("midrst_no_fe_err", (fe_cnt - fe0) + (err_cnt - err0), 0);
    hold_low(490);
    send_bits(8'hE7, 8, 9, 4, 7);
    hold_low(500);
    got = (rx_q.size() > base) ? int'(rx_q[base]) : -1;
    check("postrst_byte", got, 'hE7);
    check("postrst_count", rx_q.size() - base, 1);

    check("valid_err_overlap", overlap, 0);
    check("strobe_stretch", stretch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
